// File: rtl/pipe_ctrl_mc_pkg.sv
// Shared definitions for the pipeline stall controller: stall bus layout,
// multi-cycle sequencer state encoding and the two stall level patterns.
package pipe_ctrl_mc_pkg;

   // Stage bit positions inside the stall bus
   localparam int ST_PC  = 0;
   localparam int ST_IF  = 1;
   localparam int ST_ID  = 2;
   localparam int ST_EX  = 3;
   localparam int ST_MEM = 4;
   localparam int ST_WB  = 5;

   localparam int STALL_W = ST_WB + 1;

   typedef logic [STALL_W-1:0] stall_bus_t;

   // Multi-cycle sequencer states
   typedef enum logic [1:0] {
      MC_IDLE = 2'd0,
      MC_BUSY = 2'd1,
      MC_DONE = 2'd2
   } mc_state_t;

   // ID-level hold freezes PC/IF/ID so the ID instruction is re-presented;
   // EX-level additionally holds EX while MEM/WB keep draining.
   localparam stall_bus_t STALL_NONE   = '0;
   localparam stall_bus_t STALL_ID_LVL = stall_bus_t'((1 << ST_PC) | (1 << ST_IF) | (1 << ST_ID));
   localparam stall_bus_t STALL_EX_LVL = stall_bus_t'(STALL_ID_LVL | stall_bus_t'(1 << ST_EX));

   // Widen or narrow a stall pattern to the instance stall width.
   function automatic logic [31:0] stall_pat32(input stall_bus_t pat);
      return 32'(pat);
   endfunction

endpackage

// File: rtl/pipe_ctrl_mc_mc_seq.sv
// Multi-cycle EX operation sequencer. Holds EX for MC_LAT cycles counting
// the start cycle, then emits a one-cycle done pulse. An abort returns it
// to idle immediately without a done pulse.
//
// state   | meaning
// --------+---------------------------------------------------------------
// MC_IDLE | no operation; a start here begins one (start cycle is busy)
// MC_BUSY | operation running; counter counts down to zero
// MC_DONE | result valid in EX for this single cycle; pipeline advances
module mc_seq
   import pipe_ctrl_mc_pkg::*;
#(
   parameter int MC_LAT = 32,
   parameter int CNT_W  = 6
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   input  logic i_abort,
   output logic o_busy,
   output logic o_done
);

   mc_state_t        r_state;
   mc_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   // The start cycle plus MC_LAT-1 BUSY cycles gives MC_LAT cycles of hold,
   // and BUSY exits on the cycle the counter reads zero.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 2);

   // State and counter registers
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= MC_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state and counter update; abort wins over everything, including a start
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         MC_IDLE: begin
            if (i_start && !i_abort) begin
               w_state_nxt = MC_BUSY;
               w_cnt_nxt   = CNT_LOAD;
            end
         end
         MC_BUSY: begin
            if (i_abort) begin
               w_state_nxt = MC_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == '0) begin
               w_state_nxt = MC_DONE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         MC_DONE: begin
            w_state_nxt = MC_IDLE;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = MC_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs; busy covers the start cycle so EX is held from that cycle on
   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      if (i_rst) begin
         o_busy = (r_state == MC_BUSY) || ((r_state == MC_IDLE) && i_start);
         o_done = (r_state == MC_DONE);
      end
   end

endmodule

// File: rtl/pipe_ctrl_mc.sv
// Pipeline stall controller: merges stage stall requests into one stall
// vector, sequences multi-cycle EX operations, registers flush/redirect
// requests and counts stalled cycles.
module pipe_ctrl_mc
   import pipe_ctrl_mc_pkg::*;
#(
   parameter int STAGES = 6,
   parameter int MC_LAT = 32,
   parameter int CNT_W  = 6,
   parameter int PC_W   = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_stallreq_id,
   input  logic              i_stallreq_ex,
   input  logic              i_mc_start,
   input  logic              i_flush_req,
   input  logic [PC_W-1:0]   i_flush_pc,
   output logic [STAGES-1:0] o_stall,
   output logic              o_flush,
   output logic [PC_W-1:0]   o_new_pc,
   output logic              o_mc_busy,
   output logic              o_mc_done,
   output logic [31:0]       o_stall_cycles
);

   localparam logic [31:0]       PAT_ID_32 = stall_pat32(STALL_ID_LVL);
   localparam logic [31:0]       PAT_EX_32 = stall_pat32(STALL_EX_LVL);
   localparam logic [STAGES-1:0] PAT_ID    = PAT_ID_32[STAGES-1:0];
   localparam logic [STAGES-1:0] PAT_EX    = PAT_EX_32[STAGES-1:0];

   logic              w_mc_busy;
   logic              w_mc_done;
   logic [STAGES-1:0] w_stall;
   logic              r_flush;
   logic [PC_W-1:0]   r_new_pc;
   logic [31:0]       r_stall_cycles;

   mc_seq #(
      .MC_LAT (MC_LAT),
      .CNT_W  (CNT_W)
   ) u_mc_seq (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_mc_start),
      .i_abort (i_flush_req),
      .o_busy  (w_mc_busy),
      .o_done  (w_mc_done)
   );

   // Stall merge: a flush in flight clears all holds so the redirect lands;
   // otherwise the deepest requested level wins.
   always_comb begin
      w_stall = '0;
      if (!i_rst || r_flush) begin
         w_stall = '0;
      end else if (i_stallreq_ex || w_mc_busy) begin
         w_stall = PAT_EX;
      end else if (i_stallreq_id) begin
         w_stall = PAT_ID;
      end
   end

   // Flush pulse and redirect PC, one cycle after the request
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_flush  <= 1'b0;
         r_new_pc <= '0;
      end else begin
         r_flush <= i_flush_req;
         if (i_flush_req) begin
            r_new_pc <= i_flush_pc;
         end
      end
   end

   // Saturating count of cycles with any stage held
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_stall_cycles <= '0;
      end else if ((w_stall != '0) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign o_stall        = w_stall;
   assign o_flush        = r_flush;
   assign o_new_pc       = r_new_pc;
   assign o_mc_busy      = w_mc_busy;
   assign o_mc_done      = w_mc_done;
   assign o_stall_cycles = r_stall_cycles;

endmodule
